// File: rtl/spinn_aer_if_user_int_mux.sv
// User interface for the SpiNNaker AER boards: 7-segment scan, pushbutton mode/key select, status LEDs.
// Define USER_INT_DEBOUNCE_EN to insert the button debouncer; otherwise the synchronised level is used directly.
module spinn_aer_if_user_int_mux #(
    parameter int N_DIGITS        = 4,
    parameter int PRESCALE_BITS   = 14,
    parameter int MODE_BITS       = 3,
    parameter int LAST_MODE       = 5,
    parameter int VKS_BITS        = 1,
    parameter int LAST_VKS        = 1,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int LONG_BITS       = 24,
    parameter int ACT_BITS        = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode_sel,
    input  logic                    dump_mode,
    input  logic                    error,
    input  logic                    error_clr,
    input  logic [4*N_DIGITS-1:0]   disp_code,
    output logic [MODE_BITS-1:0]    msel,
    output logic [VKS_BITS-1:0]     vksel,
    output logic                    sel_pulse,
    output logic [7:0]              o_7seg,
    output logic [N_DIGITS-1:0]     o_strobe,
    output logic                    o_led_act,
    output logic                    o_led_dmp,
    output logic                    o_led_err
);

    localparam int DIG_W = $clog2(N_DIGITS);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic                  r_sync1, r_sync2;
    logic                  w_btn;
    state_t                r_state, w_next_state;
    logic                  w_short, w_long;
    logic [LONG_BITS-1:0]  r_hold;
    logic [MODE_BITS-1:0]  r_msel;
    logic [VKS_BITS-1:0]   r_vksel;
    logic                  r_sel_pulse;
    logic                  w_msel_wrap;
    logic [VKS_BITS-1:0]   w_vks_next;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic                  w_tick;
    logic [DIG_W-1:0]      r_curr_digit;
    logic [N_DIGITS-1:0]   r_strobe;
    logic [7:0]            r_7seg;
    logic                  w_dp;
    logic [3:0]            w_code;
    logic [ACT_BITS-1:0]   r_act;
    logic                  r_led_dmp, r_led_err;

    // Button idles high, so the synchroniser resets to the released level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= mode_sel;
            r_sync2 <= r_sync1;
        end
    end

`ifdef USER_INT_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] r_db_cnt;
    logic            r_stable;

    // Counts samples that disagree with the stable level; one agreeing sample restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_db_cnt <= '0;
            r_stable <= 1'b1;
        end else if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_stable <= r_sync2;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_btn = r_stable;
`else
    assign w_btn = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_short      = 1'b0;
        w_long       = 1'b0;
        case (r_state)
            IDLE: if (!w_btn) w_next_state = HELD;
            HELD: begin
                if (w_btn) begin
                    w_next_state = IDLE;
                    w_short      = 1'b1;
                end else if (r_hold == '1) begin
                    w_next_state = LONG;
                    w_long       = 1'b1;
                end
            end
            LONG: if (w_btn) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_msel_wrap = (r_msel == MODE_BITS'(LAST_MODE));
    assign w_vks_next  = (r_vksel == VKS_BITS'(LAST_VKS)) ? '0 : r_vksel + 1'b1;

    // The hold counter sits at zero outside HELD, so entering HELD starts it cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold      <= '0;
            r_msel      <= '0;
            r_vksel     <= '0;
            r_sel_pulse <= 1'b0;
        end else begin
            r_hold      <= (r_state == HELD) ? r_hold + 1'b1 : '0;
            r_sel_pulse <= w_short | w_long;
            if (w_short) begin
                r_msel <= w_msel_wrap ? '0 : r_msel + 1'b1;
                if (w_msel_wrap) r_vksel <= w_vks_next;
            end else if (w_long) begin
                r_vksel <= w_vks_next;
            end
        end
    end

    function automatic logic [6:0] segDecode(input logic [3:0] code);
        case (code)
            4'd0:    segDecode = 7'b0000001;
            4'd1:    segDecode = 7'b1001111;
            4'd2:    segDecode = 7'b0010010;
            4'd3:    segDecode = 7'b0000110;
            4'd4:    segDecode = 7'b1001100;
            4'd5:    segDecode = 7'b0100100;
            4'd6:    segDecode = 7'b0100000;
            4'd7:    segDecode = 7'b0001111;
            4'd8:    segDecode = 7'b0000000;
            4'd9:    segDecode = 7'b0000100;
            4'd11:   segDecode = 7'b1110010;
            4'd12:   segDecode = 7'b1100010;
            4'd13:   segDecode = 7'b1101000;
            4'd14:   segDecode = 7'b0110000;
            default: segDecode = 7'b1111111;
        endcase
    endfunction

    assign w_tick = &r_prescale;
    assign w_code = disp_code[{r_curr_digit, 2'b00} +: 4];
    assign w_dp   = !((r_curr_digit == '0) && (r_vksel != '0));

    // Strobe and segments latch the digit being left, so the display lags the counter by one dwell.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prescale   <= '0;
            r_curr_digit <= '0;
            r_strobe     <= '0;
            r_7seg       <= 8'hFF;
        end else begin
            r_prescale <= r_prescale + 1'b1;
            if (w_tick) begin
                r_curr_digit <= (r_curr_digit == DIG_W'(N_DIGITS - 1)) ? '0 : r_curr_digit + 1'b1;
                r_strobe     <= N_DIGITS'(1) << r_curr_digit;
                r_7seg       <= {w_dp, segDecode(w_code)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_act     <= '0;
            r_led_dmp <= 1'b0;
            r_led_err <= 1'b0;
        end else begin
            r_act     <= r_act + 1'b1;
            r_led_dmp <= dump_mode;
            if (error)          r_led_err <= 1'b1;
            else if (error_clr) r_led_err <= 1'b0;
        end
    end

    assign msel      = r_msel;
    assign vksel     = r_vksel;
    assign sel_pulse = r_sel_pulse;
    assign o_7seg    = r_7seg;
    assign o_strobe  = r_strobe;
    assign o_led_act = r_act[ACT_BITS-1];
    assign o_led_dmp = r_led_dmp;
    assign o_led_err = r_led_err;

endmodule
